wbuf_ctrl: RTL and testbench

Sequencing controller for the row-wide weight/activation register file (16 rows x MEM_LEN x DATA_WIDTH). It runs two phases. LOAD streams rows from an upstream valid/ready source into the buffer. STREAM reads rows 0..N-1 back, optionally repeated, to a downstream consumer such as the systolic array edge, with backpressure. It owns all buffer write/read strobes and guarantees write and read are never issued in the same cycle.

---
 rtl/wbuf_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_wbuf_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wbuf_ctrl.sv
// ---------------------------------------------------------------------------
// wbuf_ctrl -- sequencing controller for a row-wide register-file buffer.
//
// The controller runs one of two phases per command:
//   LOAD   : rows arrive from an upstream source and are written to the
//            buffer starting at row 0.
//   STREAM : rows 0..rows-1 are read back (optionally repeated) and handed to
//            a downstream consumer with backpressure.
// Buffer write and read strobes are owned here and are never active together.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A valid source holds its payload stable until the transfer. Ready
// may be asserted independently of valid.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (ready only while idle)
//   cmd_op, cmd_rows, cmd_reps  0=LOAD / 1=STREAM, row count, repetitions
//   ld_valid/ld_ready/ld_data  load row stream
//   out_valid/out_ready/out_data/out_row/out_last  streamed row output
//   done, err                 single-cycle completion / rejection pulses
//   busy                      controller not idle
//   buf_wr_*                  buffer write port
//   buf_rd_en/buf_rd_addr     buffer read request
//   buf_rd_data_i             buffer registered read data
//   dbg_state                 current FSM state (0=IDLE, 1=LOAD, 2=STREAM)
// ---------------------------------------------------------------------------
module wbuf_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_LEN    = 16,
    parameter int MEM_DEPTH  = 16,
    parameter int REP_W      = 8,
    localparam int RW        = DATA_WIDTH * MEM_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [4:0]       cmd_rows,
    input  logic [REP_W-1:0] cmd_reps,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [RW-1:0]    ld_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_data,
    output logic [3:0]       out_row,
    output logic             out_last,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic             buf_wr_en,
    output logic [3:0]       buf_wr_addr,
    output logic [RW-1:0]    buf_wr_data,
    output logic             buf_rd_en,
    output logic [3:0]       buf_rd_addr,
    input  logic [RW-1:0]    buf_rd_data_i,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    localparam logic [4:0]       DEPTH5  = 5'(MEM_DEPTH);
    localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

    state_t           state, state_n;
    logic [4:0]       rows;
    logic [REP_W-1:0] reps;
    logic [4:0]       loaded_rows;
    logic [3:0]       wr_ptr;
    logic [3:0]       rd_ptr;
    logic [REP_W-1:0] rep_cnt;
    logic             issuing;     // reads still remain to be issued

    logic cmd_fire, cmd_bad, cmd_ok;
    logic wr_fire, last_wr;
    logic issue, last_rd;
    logic final_accept;

    // Command legality: row count must fit the buffer, and a STREAM may only
    // read rows written by the most recent LOAD.
    always_comb begin
        cmd_fire = (state == S_IDLE) && cmd_valid;
        cmd_bad  = (cmd_rows == 5'd0) || (cmd_rows > DEPTH5) ||
                   (cmd_op && (cmd_rows > loaded_rows));
        cmd_ok   = cmd_fire && !cmd_bad;
    end

    always_comb begin
        wr_fire      = (state == S_LOAD) && ld_valid;
        last_wr      = ({1'b0, wr_ptr} == (rows - 5'd1));
        // A new read may replace the presented beat only if the consumer
        // takes it this cycle, so stalled outputs stay stable.
        issue        = (state == S_STREAM) && issuing && (!out_valid || out_ready);
        last_rd      = ({1'b0, rd_ptr} == (rows - 5'd1));
        // Accept with nothing left to issue means the final beat was taken.
        final_accept = (state == S_STREAM) && !issuing && out_valid && out_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (cmd_ok) state_n = cmd_op ? S_STREAM : S_LOAD;
            S_LOAD:   if (wr_fire && last_wr) state_n = S_IDLE;
            S_STREAM: if (final_accept) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready   = (state == S_IDLE);
        busy        = (state != S_IDLE);
        ld_ready    = (state == S_LOAD);
        buf_wr_en   = wr_fire;
        buf_wr_addr = wr_ptr;
        buf_wr_data = ld_data;
        buf_rd_en   = issue;
        buf_rd_addr = rd_ptr;
        out_data    = buf_rd_data_i;
        dbg_state   = state;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rows        <= 5'd0;
            reps        <= '0;
            loaded_rows <= 5'd0;
            wr_ptr      <= 4'd0;
            rd_ptr      <= 4'd0;
            rep_cnt     <= '0;
            issuing     <= 1'b0;
            out_valid   <= 1'b0;
            out_row     <= 4'd0;
            out_last    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            if (cmd_fire) begin
                if (cmd_bad) begin
                    err <= 1'b1;
                end else begin
                    rows    <= cmd_rows;
                    reps    <= (cmd_reps == '0) ? REP_ONE : cmd_reps;
                    wr_ptr  <= 4'd0;
                    rd_ptr  <= 4'd0;
                    rep_cnt <= '0;
                    issuing <= cmd_op;
                end
            end

            if (wr_fire) begin
                wr_ptr <= wr_ptr + 4'd1;
                if (last_wr) begin
                    loaded_rows <= rows;
                    done        <= 1'b1;
                end
            end

            if (issue) begin
                out_valid <= 1'b1;
                out_row   <= rd_ptr;
                out_last  <= last_rd;
                if (last_rd) begin
                    rd_ptr  <= 4'd0;
                    rep_cnt <= rep_cnt + REP_ONE;
                    if (rep_cnt == (reps - REP_ONE)) issuing <= 1'b0;
                end else begin
                    rd_ptr <= rd_ptr + 4'd1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                if (final_accept) done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wbuf_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for wbuf_ctrl. Inputs change on the falling edge and outputs are
// sampled 1 time unit later. A small behavioural buffer (registered read)
// sits on the buffer ports so streamed data can be checked end to end.
// ---------------------------------------------------------------------------
module tb_wbuf_ctrl;

    localparam int DW    = 16;
    localparam int ML    = 16;
    localparam int RW    = DW * ML;
    localparam int REP_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_op = 1'b0;
    logic [4:0]       cmd_rows = 5'd0;
    logic [REP_W-1:0] cmd_reps = '0;
    logic             ld_valid = 1'b0;
    logic             ld_ready;
    logic [RW-1:0]    ld_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [RW-1:0]    out_data;
    logic [3:0]       out_row;
    logic             out_last;
    logic             done;
    logic             err;
    logic             busy;
    logic             buf_wr_en;
    logic [3:0]       buf_wr_addr;
    logic [RW-1:0]    buf_wr_data;
    logic             buf_rd_en;
    logic [3:0]       buf_rd_addr;
    logic [RW-1:0]    buf_rd_data_i;
    logic [1:0]       dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    wbuf_ctrl #(.DATA_WIDTH(DW), .MEM_LEN(ML), .MEM_DEPTH(16), .REP_W(REP_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rows(cmd_rows), .cmd_reps(cmd_reps),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_last(out_last),
        .done(done), .err(err), .busy(busy),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data_i(buf_rd_data_i),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- buffer model ----------------
    logic [RW-1:0] mem [16];
    always @(posedge clk) begin
        if (buf_wr_en) mem[buf_wr_addr] <= buf_wr_data;
        if (buf_rd_en) buf_rd_data_i <= mem[buf_rd_addr];
    end

    // Row pattern: every element equals k.
    function automatic logic [RW-1:0] row_pat(input int k);
        logic [RW-1:0] r;
        logic [DW-1:0] e;
        e = DW'(k);
        for (int i = 0; i < ML; i++) r[i*DW +: DW] = e;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic op, input logic [4:0] rows, input logic [REP_W-1:0] reps);
        step();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rows  = rows;
        cmd_reps  = reps;
        #1;
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL cmd_ready got %b want 1", cmd_ready); else n_pass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        #1;
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); else n_pass++;
        n_total++; if ({busy, ld_ready, out_valid, out_last, done, err, buf_wr_en, buf_rd_en} !== 8'h00)
            $display("FAIL reset_outputs got %b want 00000000",
                     {busy, ld_ready, out_valid, out_last, done, err, buf_wr_en, buf_rd_en});
        else n_pass++;
        n_total++; if (out_row !== 4'd0) $display("FAIL reset_out_row got %0d want 0", out_row); else n_pass++;
        n_total++; if (dbg_state !== 2'd0) $display("FAIL reset_state got %0d want 0", dbg_state); else n_pass++;
    endtask

    // LOAD nrows rows with data row_pat(base+k); gaps selects valid pattern 1100...
    task automatic test_load(input int nrows, input int base, input bit gaps);
        int beats = 0;
        int cyc = 0;
        send_cmd(1'b0, 5'(nrows), '0);
        while (beats < nrows && cyc < 200) begin
            step();
            cyc++;
            ld_valid = gaps ? (((cyc - 1) % 4) < 2) : 1'b1;
            ld_data  = row_pat(base + beats);
            #1;
            n_total++; if (ld_ready !== 1'b1) $display("FAIL load_ready cyc %0d got %b want 1", cyc, ld_ready); else n_pass++;
            n_total++; if (buf_rd_en !== 1'b0 || done !== 1'b0) $display("FAIL load_rd_or_done cyc %0d got %b%b want 00", cyc, buf_rd_en, done); else n_pass++;
            n_total++; if (buf_wr_en !== ld_valid) $display("FAIL load_wr_en cyc %0d got %b want %b", cyc, buf_wr_en, ld_valid); else n_pass++;
            if (ld_valid) begin
                n_total++; if (buf_wr_addr !== 4'(beats)) $display("FAIL load_addr beat %0d got %0d want %0d", beats, buf_wr_addr, beats); else n_pass++;
                n_total++; if (buf_wr_data !== row_pat(base + beats)) $display("FAIL load_data beat %0d got %h want %h", beats, buf_wr_data, row_pat(base + beats)); else n_pass++;
                beats++;
            end
        end
        n_total++; if (beats != nrows) $display("FAIL load_timeout beats got %0d want %0d", beats, nrows); else n_pass++;
        // Cycle after the last beat: valid still offered, nothing may be written.
        step();
        ld_valid = 1'b1;
        ld_data  = row_pat(999);
        #1;
        n_total++; if (done !== 1'b1) $display("FAIL load_done got %b want 1", done); else n_pass++;
        n_total++; if (ld_ready !== 1'b0 || buf_wr_en !== 1'b0) $display("FAIL load_after_ready_wr got %b%b want 00", ld_ready, buf_wr_en); else n_pass++;
        n_total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL load_idle got ready %b busy %b want 1 0", cmd_ready, busy); else n_pass++;
        step();
        ld_valid = 1'b0;
        #1;
        n_total++; if (done !== 1'b0) $display("FAIL load_done_width got %b want 0", done); else n_pass++;
    endtask

    // STREAM nrows rows x reps; toggle drives out_ready 1010..., else held high.
    task automatic test_stream(input int nrows, input int reps, input bit toggle, input int base);
        int eff_reps = (reps == 0) ? 1 : reps;
        int total = nrows * eff_reps;
        int beats = 0;
        int cyc = 0;
        int last_cyc = 0;
        int exp_row;
        bit stall_prev = 1'b0;
        logic [3:0] prev_row = '0;
        logic [RW-1:0] prev_data = '0;
        send_cmd(1'b1, 5'(nrows), REP_W'(reps));
        while (beats < total && cyc < 400) begin
            step();
            cyc++;
            out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            #1;
            n_total++; if (buf_wr_en !== 1'b0 || done !== 1'b0) $display("FAIL stream_wr_or_done cyc %0d got %b%b want 00", cyc, buf_wr_en, done); else n_pass++;
            if (cyc == 1) begin
                n_total++; if (out_valid !== 1'b0) $display("FAIL stream_lat1 got %b want 0", out_valid); else n_pass++;
            end
            if (cyc == 2) begin
                n_total++; if (out_valid !== 1'b1) $display("FAIL stream_lat2 got %b want 1", out_valid); else n_pass++;
            end
            if (stall_prev) begin
                n_total++; if (out_valid !== 1'b1 || out_row !== prev_row || out_data !== prev_data)
                    $display("FAIL stream_stall_hold cyc %0d got v%b row %0d want v1 row %0d", cyc, out_valid, out_row, prev_row);
                else n_pass++;
            end
            if (out_valid && !out_ready) begin
                n_total++; if (buf_rd_en !== 1'b0) $display("FAIL stream_rd_in_stall cyc %0d got %b want 0", cyc, buf_rd_en); else n_pass++;
            end
            if (out_valid && out_ready) begin
                exp_row = beats % nrows;
                n_total++; if (out_row !== 4'(exp_row)) $display("FAIL stream_row beat %0d got %0d want %0d", beats, out_row, exp_row); else n_pass++;
                n_total++; if (out_data !== row_pat(base + exp_row)) $display("FAIL stream_data beat %0d got %h want %h", beats, out_data, row_pat(base + exp_row)); else n_pass++;
                n_total++; if (out_last !== (exp_row == nrows - 1)) $display("FAIL stream_last beat %0d got %b want %b", beats, out_last, (exp_row == nrows - 1)); else n_pass++;
                beats++;
                last_cyc = cyc;
            end
            stall_prev = out_valid && !out_ready;
            prev_row   = out_row;
            prev_data  = out_data;
        end
        n_total++; if (beats != total) $display("FAIL stream_timeout beats got %0d want %0d", beats, total); else n_pass++;
        if (!toggle) begin
            n_total++; if (last_cyc != total + 1) $display("FAIL stream_throughput last beat cyc got %0d want %0d", last_cyc, total + 1); else n_pass++;
        end
        step();
        out_ready = 1'b1;
        #1;
        n_total++; if (done !== 1'b1) $display("FAIL stream_done got %b want 1", done); else n_pass++;
        n_total++; if (out_valid !== 1'b0 || busy !== 1'b0 || buf_rd_en !== 1'b0) $display("FAIL stream_end got v%b busy%b rd%b want 000", out_valid, busy, buf_rd_en); else n_pass++;
        step();
        #1;
        n_total++; if (done !== 1'b0) $display("FAIL stream_done_width got %b want 0", done); else n_pass++;
    endtask

    task automatic test_err(input logic op, input logic [4:0] rows, input logic [REP_W-1:0] reps);
        send_cmd(op, rows, reps);
        n_total++; if (buf_rd_en !== 1'b0) $display("FAIL err_rd0 rows %0d got %b want 0", rows, buf_rd_en); else n_pass++;
        step();
        #1;
        n_total++; if (err !== 1'b1 || done !== 1'b0) $display("FAIL err_pulse rows %0d got err %b done %b want 1 0", rows, err, done); else n_pass++;
        n_total++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || buf_rd_en !== 1'b0) $display("FAIL err_idle rows %0d got busy %b ready %b rd %b want 0 1 0", rows, busy, cmd_ready, buf_rd_en); else n_pass++;
        step();
        #1;
        n_total++; if (err !== 1'b0 || buf_rd_en !== 1'b0 || busy !== 1'b0) $display("FAIL err_after rows %0d got err %b rd %b busy %b want 0 0 0", rows, err, buf_rd_en, busy); else n_pass++;
    endtask

    task automatic test_reset_mid_stream();
        int beats = 0;
        int cyc = 0;
        send_cmd(1'b1, 5'd10, 8'd1);
        while (beats < 3 && cyc < 50) begin
            step();
            cyc++;
            out_ready = 1'b1;
            #1;
            if (out_valid && out_ready) beats++;
        end
        n_total++; if (beats != 3) $display("FAIL midrst_beats got %0d want 3", beats); else n_pass++;
        step();
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0)
            $display("FAIL midrst_state got v%b busy%b ready%b done%b want 0 0 1 0", out_valid, busy, cmd_ready, done);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            n_total++; if (done !== 1'b0 || buf_rd_en !== 1'b0) $display("FAIL midrst_quiet cyc %0d got done %b rd %b want 0 0", i, done, buf_rd_en); else n_pass++;
        end
        // loaded_rows cleared by reset, so any STREAM is rejected.
        test_err(1'b1, 5'd1, 8'd1);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_load(16, 0, 1'b0);
        test_stream(4, 3, 1'b0, 0);
        test_stream(8, 1, 1'b1, 0);
        test_reset_mid_stream();
        test_load(5, 0, 1'b0);
        test_err(1'b1, 5'd6, 8'd1);
        test_err(1'b0, 5'd0, 8'd1);
        test_err(1'b1, 5'd17, 8'd1);
        test_load(4, 32, 1'b1);
        test_stream(4, 0, 1'b0, 32);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
